dma_cfg_arbiter: RTL and testbench

- Shares one single-beat register-configuration port between NumReq requesters (default 4, one per iDMA config window DMA_CFG_1..4).
- Round-robin arbitration.
- One transaction outstanding at a time.
- Response is routed back to the granted requester.
- A watchdog completes hung transactions with an error, so no requester can lock the shared port.

---
 rtl/dma_cfg_arb_pkg.sv | 31 +++
 rtl/dma_cfg_arbiter_rr_pick.sv | 30 +++
 rtl/dma_cfg_arbiter.sv | 129 ++++++++++++
 tb/tb_dma_cfg_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_cfg_arb_pkg.sv
// Shared types for the DMA config-port arbiter: FSM states, request and
// response records, and the default requester count.
package dma_cfg_arb_pkg;

   // Local copy of ariane_soc::NrDmaMasters so this slice elaborates on its own.
   localparam int unsigned NrDmaMasters = 4;

   // Widest address/data the stored request/response records can hold.
   localparam int unsigned CfgAddrWidth = 64;
   localparam int unsigned CfgDataWidth = 64;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;

   typedef struct packed {
      logic [CfgAddrWidth-1:0]   addr;
      logic                      we;
      logic [CfgDataWidth-1:0]   wdata;
      logic [CfgDataWidth/8-1:0] be;
   } cfg_req_t;

   typedef struct packed {
      logic [CfgDataWidth-1:0] rdata;
      logic                    err;
   } cfg_rsp_t;

   // Index width that stays legal for a count of one.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dma_cfg_arbiter_rr_pick.sv
// Round-robin priority selector: first set request at or after ptr, wrapping.
module rr_pick import dma_cfg_arb_pkg::*; #(
   parameter int unsigned NumReq = 4,
   parameter int unsigned IdxW   = idx_w(NumReq)
) (
   input  logic [NumReq-1:0] req,
   input  logic [IdxW-1:0]   ptr,
   output logic [NumReq-1:0] gnt,
   output logic [IdxW-1:0]   idx,
   output logic              any
);

   // Walk the requests starting at ptr; the first one found owns the grant.
   always_comb begin
      logic [IdxW-1:0] j;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      j   = '0;
      for (int unsigned k = 0; k < NumReq; k++) begin
         j = IdxW'((32'(ptr) + k) % NumReq);
         if (!any && req[j]) begin
            any    = 1'b1;
            gnt[j] = 1'b1;
            idx    = j;
         end
      end
   end

endmodule

// File: rtl/dma_cfg_arbiter.sv
// Shares one single-beat config port between NumReq requesters, round-robin,
// one transaction in flight, with a watchdog that errors out hung accesses.
module dma_cfg_arbiter import dma_cfg_arb_pkg::*; #(
   parameter int unsigned NumReq        = NrDmaMasters,
   parameter int unsigned AddrWidth     = 64,   // at most CfgAddrWidth
   parameter int unsigned DataWidth     = 64,   // at most CfgDataWidth
   parameter int unsigned TimeoutCycles = 1024  // 0 disables the watchdog
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic [NumReq-1:0]                   req_valid_i,
   output logic [NumReq-1:0]                   req_ready_o,
   input  logic [NumReq-1:0][AddrWidth-1:0]    req_addr_i,
   input  logic [NumReq-1:0]                   req_we_i,
   input  logic [NumReq-1:0][DataWidth-1:0]    req_wdata_i,
   input  logic [NumReq-1:0][DataWidth/8-1:0]  req_be_i,
   output logic [NumReq-1:0]                   rsp_valid_o,
   output logic [DataWidth-1:0]                rsp_rdata_o,
   output logic                                rsp_err_o,
   output logic                                out_valid_o,
   input  logic                                out_ready_i,
   output logic [AddrWidth-1:0]                out_addr_o,
   output logic                                out_we_o,
   output logic [DataWidth-1:0]                out_wdata_o,
   output logic [DataWidth/8-1:0]              out_be_o,
   input  logic                                down_rsp_valid_i,
   input  logic [DataWidth-1:0]                down_rsp_rdata_i,
   input  logic                                down_rsp_err_i,
   output logic                                timeout_o
);

   localparam int unsigned IdxW = idx_w(NumReq);
   localparam int unsigned CntW = idx_w(TimeoutCycles);

   arb_state_e        state;
   logic [IdxW-1:0]   ptr;
   logic [IdxW-1:0]   gidx;
   cfg_req_t          lat;
   cfg_rsp_t          cap;
   logic [CntW-1:0]   cnt;
   logic [NumReq-1:0] win_gnt;
   logic [IdxW-1:0]   win_idx;
   logic              win_any;
   logic              to_hit;

   rr_pick #(
      .NumReq (NumReq),
      .IdxW   (IdxW)
   ) u_pick (
      .req (req_valid_i),
      .ptr (ptr),
      .gnt (win_gnt),
      .idx (win_idx),
      .any (win_any)
   );

   // Grant is offered only while idle, and never while reset is held.
   assign req_ready_o = (state == IDLE && !rst_i) ? win_gnt : '0;

   // Last allowed response-wait cycle; a response arriving in it still wins.
   assign to_hit = (TimeoutCycles != 0) && (cnt == CntW'(TimeoutCycles - 1));

   assign out_addr_o  = lat.addr[AddrWidth-1:0];
   assign out_we_o    = lat.we;
   assign out_wdata_o = lat.wdata[DataWidth-1:0];
   assign out_be_o    = lat.be[DataWidth/8-1:0];
   assign rsp_rdata_o = cap.rdata[DataWidth-1:0];
   assign rsp_err_o   = cap.err;

   // Arbitration FSM; all strobes are registered, so they land one cycle
   // after the event that causes them. Responses outside WAIT are ignored.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         ptr         <= '0;
         gidx        <= '0;
         lat         <= '0;
         cap         <= '0;
         cnt         <= '0;
         out_valid_o <= 1'b0;
         rsp_valid_o <= '0;
         timeout_o   <= 1'b0;
      end else begin
         rsp_valid_o <= '0;
         timeout_o   <= 1'b0;
         unique case (state)
            IDLE: begin
               if (win_any) begin
                  gidx        <= win_idx;
                  lat.addr    <= CfgAddrWidth'(req_addr_i[win_idx]);
                  lat.we      <= req_we_i[win_idx];
                  lat.wdata   <= CfgDataWidth'(req_wdata_i[win_idx]);
                  lat.be      <= (CfgDataWidth/8)'(req_be_i[win_idx]);
                  out_valid_o <= 1'b1;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               if (out_ready_i) begin
                  out_valid_o <= 1'b0;
                  cnt         <= '0;
                  state       <= WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt + 1'b1;
               if (down_rsp_valid_i) begin
                  cap.rdata   <= CfgDataWidth'(down_rsp_rdata_i);
                  cap.err     <= down_rsp_err_i;
                  rsp_valid_o <= NumReq'(1) << gidx;
                  state       <= RESP;
               end else if (to_hit) begin
                  cap.rdata   <= '0;
                  cap.err     <= 1'b1;
                  timeout_o   <= 1'b1;
                  rsp_valid_o <= NumReq'(1) << gidx;
                  state       <= RESP;
               end
            end
            RESP: begin
               ptr   <= (gidx == IdxW'(NumReq - 1)) ? '0 : gidx + 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dma_cfg_arbiter.sv
// Randomized + directed bench for dma_cfg_arbiter against a transaction-level
// timeline model (grant -> accept -> response/timeout -> response strobe).
module tb_dma_cfg_arbiter;

   localparam int N  = 4;
   localparam int AW = 64;
   localparam int DW = 64;
   localparam int BW = 8;
   localparam int TO = 8;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [N-1:0]         req_valid, req_ready, req_we, rsp_valid;
   logic [N-1:0][AW-1:0] req_addr;
   logic [N-1:0][DW-1:0] req_wdata;
   logic [N-1:0][BW-1:0] req_be;
   logic [DW-1:0]        rsp_rdata;
   logic                 rsp_err;
   logic                 out_valid, out_ready, out_we, timeout;
   logic [AW-1:0]        out_addr;
   logic [DW-1:0]        out_wdata;
   logic [BW-1:0]        out_be;
   logic                 drv, derr;
   logic [DW-1:0]        drd;

   always #5 clk = ~clk;

   dma_cfg_arbiter #(
      .NumReq(N), .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TO)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
      .req_we_i(req_we), .req_wdata_i(req_wdata), .req_be_i(req_be),
      .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_addr_o(out_addr),
      .out_we_o(out_we), .out_wdata_o(out_wdata), .out_be_o(out_be),
      .down_rsp_valid_i(drv), .down_rsp_rdata_i(drd), .down_rsp_err_i(derr),
      .timeout_o(timeout)
   );

   int nchk = 0, nerr = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // requester side
   bit            pend [N];
   logic [AW-1:0] p_addr [N];
   bit            p_we [N];
   logic [DW-1:0] p_wd [N];
   logic [BW-1:0] p_be [N];

   // transaction timeline (cycle numbers of each event, -1 = not yet)
   bit            busy = 0;
   int            gi = 0, g_cyc = 0, acc = -1, rcyc = -1, late_cyc = -1, mptr = 0, cyc = 0;
   logic [AW-1:0] e_addr;
   bit            e_we;
   logic [DW-1:0] e_wd;
   logic [BW-1:0] e_be;
   logic [DW-1:0] r_data, plan_data;
   bit            r_err, r_to, plan_err;
   int            plan_dly;

   // stimulus knobs
   int            gen_pct = 0, rdy_mode = 1, dly_force = 1;
   bit            refill_all = 0, stray_en = 0, withdraw_en = 0, err_force = 0;
   logic [DW-1:0] data_force = '0;

   int grants[$];
   int gcycs[$];

   // Round-robin rule: first pending index at or after p, wrapping.
   function automatic int pick(input bit [N-1:0] v, input int p);
      int j;
      for (int k = 0; k < N; k++) begin
         j = (p + k) % N;
         if (v[j[1:0]]) return j;
      end
      return -1;
   endfunction

   function automatic bit any_pend();
      for (int i = 0; i < N; i++) if (pend[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic new_req(input int i);
      pend[i]   = 1'b1;
      p_addr[i] = {$urandom, $urandom};
      p_we[i]   = 1'($urandom);
      p_wd[i]   = {$urandom, $urandom};
      p_be[i]   = 8'($urandom);
   endtask

   // One clock: drive requesters/downstream, then check every output.
   task automatic cycle();
      bit [N-1:0]   v;
      logic [N-1:0] oh;
      int           w;
      bit           stray_ok;
      @(posedge clk); #1;
      cyc++;
      if (busy && rcyc >= 0 && cyc > rcyc) busy = 0;
      for (int i = 0; i < N; i++) begin
         if (pend[i] && withdraw_en && $urandom_range(15) == 0) pend[i] = 1'b0;
         else if (!pend[i] && (refill_all || $urandom_range(99) < gen_pct)) new_req(i);
         v[i] = pend[i];
         req_valid[i] = pend[i];
         req_addr[i]  = p_addr[i];
         req_we[i]    = p_we[i];
         req_wdata[i] = p_wd[i];
         req_be[i]    = p_be[i];
      end
      out_ready = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : ($urandom_range(2) != 0);
      stray_ok = !(busy && acc >= 0 && cyc > acc && cyc < rcyc);
      drv = 1'b0; drd = '0; derr = 1'b0;
      if (cyc == late_cyc) begin
         drv = 1'b1; drd = plan_data; derr = plan_err;
      end else if (stray_en && stray_ok && $urandom_range(7) == 0) begin
         drv = 1'b1; drd = {$urandom, $urandom}; derr = 1'($urandom);
      end
      #1;
      // downstream request: offered from the cycle after grant until accepted
      chk("out_valid", out_valid, busy && cyc > g_cyc && acc < 0);
      if (busy && cyc > g_cyc && acc < 0) begin
         chk("out_addr", out_addr, e_addr);
         chk("out_we", out_we, e_we);
         chk("out_wdata", out_wdata, e_wd);
         chk("out_be", out_be, e_be);
         if (out_ready) begin
            acc       = cyc;
            plan_dly  = (dly_force != 0) ? dly_force : $urandom_range(11, 1);
            plan_data = (dly_force != 0) ? data_force : {$urandom, $urandom};
            plan_err  = (dly_force != 0) ? err_force : 1'($urandom);
            late_cyc  = acc + plan_dly;
            if (plan_dly <= TO) begin
               rcyc = late_cyc + 1; r_data = plan_data; r_err = plan_err; r_to = 0;
            end else begin
               rcyc = acc + TO + 1; r_data = '0; r_err = 1; r_to = 1;
            end
         end
      end
      // response strobe
      if (busy && cyc == rcyc) begin
         oh = '0; oh[gi[1:0]] = 1'b1;
         chk("rsp_valid", rsp_valid, oh);
         chk("rsp_rdata", rsp_rdata, r_data);
         chk("rsp_err", rsp_err, r_err);
         chk("timeout", timeout, r_to);
         mptr = (gi + 1) % N;
      end else begin
         chk("rsp_valid_idle", rsp_valid, 0);
         chk("timeout_idle", timeout, 0);
      end
      // grant
      w = busy ? -1 : pick(v, mptr);
      oh = '0;
      if (w >= 0) oh[w[1:0]] = 1'b1;
      chk("req_ready", req_ready, oh);
      if (w >= 0) begin
         busy = 1; gi = w; g_cyc = cyc; acc = -1; rcyc = -1;
         e_addr = p_addr[w]; e_we = p_we[w]; e_wd = p_wd[w]; e_be = p_be[w];
         pend[w] = 1'b0;
         grants.push_back(w);
         gcycs.push_back(cyc);
      end
   endtask

   // Run until nothing is pending, idle, and any planned late response is past.
   task automatic drain();
      int n = 0;
      while ((busy || any_pend() || cyc <= late_cyc) && n < 300) begin
         cycle();
         n++;
      end
      chk("drain_bound", n >= 300, 0);
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_ready"}, req_ready, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_rsp_valid"}, rsp_valid, 0);
      chk({tag, "_timeout"}, timeout, 0);
      chk({tag, "_rdata"}, rsp_rdata, 0);
      chk({tag, "_err"}, rsp_err, 0);
      chk({tag, "_addr"}, out_addr, 0);
   endtask

   initial begin
      int exp_ord[5] = '{0, 1, 2, 3, 0};
      int n0;
      for (int i = 0; i < N; i++) begin
         pend[i] = 0; p_addr[i] = '0; p_we[i] = 0; p_wd[i] = '0; p_be[i] = '0;
      end
      req_addr = '0; req_we = '0; req_wdata = '0; req_be = '0;
      out_ready = 1'b0; drv = 1'b0; drd = '0; derr = 1'b0;
      req_valid = '1;
      #12;
      chk_quiet("reset");
      req_valid = '0;
      @(negedge clk);
      rst = 1'b0;

      // all four held valid: order 0,1,2,3,0, four cycles apart
      refill_all = 1; rdy_mode = 1; dly_force = 1;
      repeat (17) cycle();
      refill_all = 0;
      chk("t2_count", grants.size(), 5);
      for (int k = 0; k < 5 && k < grants.size(); k++) chk("t2_order", grants[k], exp_ord[k]);
      for (int k = 0; k + 1 < gcycs.size() && k < 4; k++) chk("t2_spacing", gcycs[k+1] - gcycs[k], 4);
      drain();

      // single requester 2, zero-wait read of DEAD_BEEF
      pend[2] = 1; p_addr[2] = 64'h5000_1008; p_we[2] = 0; p_wd[2] = '0; p_be[2] = 8'hFF;
      data_force = 64'hDEAD_BEEF; err_force = 0; dly_force = 1;
      n0 = grants.size();
      repeat (4) cycle();
      chk("t1_grant", grants[grants.size()-1], 2);
      chk("t1_latency", gcycs[gcycs.size()-1] + 3, rcyc);
      drain();

      // back-pressure: 5 stalled issue cycles, second requester must wait
      new_req(1); new_req(3);
      rdy_mode = 2;
      n0 = grants.size();
      repeat (6) cycle();
      chk("t3_one_grant", grants.size() - n0, 1);
      rdy_mode = 1; dly_force = 2;
      drain();

      // timeout, then a late response three cycles after the pulse
      new_req(0);
      dly_force = 12; data_force = 64'h0BAD;
      drain();

      // response on the watchdog's last cycle: response wins
      new_req(1);
      dly_force = 8; err_force = 1; data_force = 64'h1234_5678_9ABC_DEF0;
      drain();
      err_force = 0;

      // randomized traffic with stalls, strays, withdrawals and timeouts
      gen_pct = 30; stray_en = 1; withdraw_en = 1; rdy_mode = 0; dly_force = 0;
      repeat (3000) cycle();
      gen_pct = 0; withdraw_en = 0; rdy_mode = 1;
      drain();

      // reset in WAIT: pointer returns to 0 and a stale response is dropped
      stray_en = 0; dly_force = 1;
      new_req(1);
      drain();
      new_req(3);
      dly_force = 12;
      repeat (4) cycle();
      #2 rst = 1'b1;
      #1 chk_quiet("t6_async");
      busy = 0; mptr = 0; acc = -1; rcyc = -1; late_cyc = -1;
      for (int i = 0; i < N; i++) pend[i] = 0;
      repeat (2) @(posedge clk);
      #1 chk_quiet("t6_held");
      @(negedge clk);
      rst = 1'b0;
      late_cyc = cyc + 1; plan_data = 64'hFFFF_0000_FFFF_0000; plan_err = 1;
      dly_force = 1;
      refill_all = 1;
      cycle();
      refill_all = 0;
      chk("t6_winner", grants[grants.size()-1], 0);
      drain();

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_time_limit: got expired expected completion");
      $fatal(1);
   end

endmodule
